// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: LEGv8 load-use stall (LOAD_LAT cycles) and branch flush control.
// Optional saturating performance counters enabled by HAZARD_PERF_CNT_EN.
module hazard_ctrl_param #(
   parameter int REG_W    = 5,
   parameter int ZERO_REG = 31,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_rn_used,
   input  logic             id_rm_used,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memRead,
   input  logic             branch_taken,
   output logic             stall,
   output logic             bubble,
   output logic             flush,
   output logic             hazard_detected,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);
   typedef enum logic {IDLE, STALL} state_t;
   state_t     state;
   logic [2:0] cnt;
   logic       hit;
   if (LOAD_LAT < 1 || LOAD_LAT > 7) begin : g_bad_lat
      $error("hazard_ctrl_param: LOAD_LAT must be in 1..7");
   end
   assign hit = ex_memRead && ex_rd != REG_W'(ZERO_REG) &&
                ((id_rn_used && id_rn == ex_rd) || (id_rm_used && id_rm == ex_rd));
   // Outputs are gated by reset so they drop the moment reset goes low.
   assign flush           = reset && branch_taken;
   assign stall           = reset && !branch_taken && (state == STALL || hit);
   assign bubble          = stall;
   assign hazard_detected = stall || flush;
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (branch_taken) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (state == IDLE) begin
         if (hit && LOAD_LAT > 1) begin
            state <= STALL;
            cnt   <= 3'(LOAD_LAT - 1);
         end
      end else begin
         cnt <= cnt - 3'd1;
         if (cnt == 3'd1) state <= IDLE;
      end
   end
`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
         if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
      end
   end
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed checks on four instances with LOAD_LAT = 1..4 sharing stimulus.
module tb_hazard_ctrl_param;
   logic        clk = 0;
   logic        reset = 0;
   logic [4:0]  id_rn = 0, id_rm = 0, ex_rd = 0;
   logic        id_rn_used = 0, id_rm_used = 0, ex_memRead = 0, branch_taken = 0;
   logic [4:1]  st, bb, fl, hd;
   logic [31:0] sc [1:4];
   logic [31:0] fc [1:4];
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 1; g <= 4; g++) begin : g_dut
      hazard_ctrl_param #(.LOAD_LAT(g)) u (
         .CLOCK_50(clk), .reset(reset),
         .id_rn(id_rn), .id_rm(id_rm), .id_rn_used(id_rn_used), .id_rm_used(id_rm_used),
         .ex_rd(ex_rd), .ex_memRead(ex_memRead), .branch_taken(branch_taken),
         .stall(st[g]), .bubble(bb[g]), .flush(fl[g]), .hazard_detected(hd[g]),
         .stall_count(sc[g]), .flush_count(fc[g]));
   end

   function automatic logic [31:0] expc(input logic [31:0] v);
`ifdef HAZARD_PERF_CNT_EN
      return v;
`else
      return (v == 32'hffff_ffff) ? 32'd0 : 32'd0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic [4:1] es, input logic ef);
      for (int g = 1; g <= 4; g++) begin
         chk($sformatf("%s_stall_u%0d", tag, g), 32'(st[g]), 32'(es[g]));
         chk($sformatf("%s_bubble_u%0d", tag, g), 32'(bb[g]), 32'(es[g]));
         chk($sformatf("%s_flush_u%0d", tag, g), 32'(fl[g]), 32'(ef));
         chk($sformatf("%s_hd_u%0d", tag, g), 32'(hd[g]), 32'(es[g] | ef));
      end
   endtask

   task automatic chk_cnt(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] s3, input logic [31:0] s4, input logic [31:0] f);
      logic [31:0] se [1:4];
      se[1] = s1; se[2] = s2; se[3] = s3; se[4] = s4;
      for (int g = 1; g <= 4; g++) begin
         chk($sformatf("%s_scnt_u%0d", tag, g), sc[g], expc(se[g]));
         chk($sformatf("%s_fcnt_u%0d", tag, g), fc[g], expc(f));
      end
   endtask

   task automatic drive(input logic [4:0] rn, input logic [4:0] rm, input logic rnu,
                        input logic rmu, input logic [4:0] rd, input logic mr, input logic br);
      id_rn = rn; id_rm = rm; id_rn_used = rnu; id_rm_used = rmu;
      ex_rd = rd; ex_memRead = mr; branch_taken = br;
   endtask

   task automatic idle(input logic br);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, br);
   endtask

   task automatic hit2();
      drive(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
   endtask

   task automatic cycle_idle(input string tag, input logic [4:1] es);
      @(negedge clk); idle(1'b0); #1 chk_cyc(tag, es, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk); reset = 0; hit2(); branch_taken = 1;
      #1 chk_cyc({tag, "_low"}, 4'b0000, 1'b0);
      chk_cnt({tag, "_low"}, 0, 0, 0, 0, 0);
      @(negedge clk); reset = 1; idle(1'b0);
      #1 chk_cyc({tag, "_rel"}, 4'b0000, 1'b0);
   endtask

   initial begin
      // Reset held from time zero with hazard and branch inputs active.
      hit2(); branch_taken = 1;
      #1 chk_cyc("rst0", 4'b0000, 1'b0);
      chk_cnt("rst0", 0, 0, 0, 0, 0);
      @(negedge clk); reset = 1; idle(1'b0);
      #1 chk_cyc("rst0_rel", 4'b0000, 1'b0);

      // Basic load-use: stall lengths equal LOAD_LAT.
      @(negedge clk); hit2(); #1 chk_cyc("a0", 4'b1111, 1'b0);
      cycle_idle("a1", 4'b1110);
      cycle_idle("a2", 4'b1100);
      cycle_idle("a3", 4'b1000);
      cycle_idle("a4", 4'b0000);
      chk_cnt("a", 1, 2, 3, 4, 0);

      // Non-hazards: XZR destination, unused source, non-load.
      @(negedge clk); drive(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0);
      #1 chk_cyc("xzr", 4'b0000, 1'b0);
      @(negedge clk); drive(5'd5, 5'd7, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
      #1 chk_cyc("unused", 4'b0000, 1'b0);
      @(negedge clk); drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0);
      #1 chk_cyc("noload", 4'b0000, 1'b0);

      // rm-only match, then both sources matching counts as one hazard.
      @(negedge clk); drive(5'd1, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      #1 chk_cyc("rm0", 4'b1111, 1'b0);
      cycle_idle("rm1", 4'b1110);
      cycle_idle("rm2", 4'b1100);
      cycle_idle("rm3", 4'b1000);
      cycle_idle("rm4", 4'b0000);
      @(negedge clk); drive(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
      #1 chk_cyc("both0", 4'b1111, 1'b0);
      cycle_idle("both1", 4'b1110);
      cycle_idle("both2", 4'b1100);
      cycle_idle("both3", 4'b1000);
      cycle_idle("both4", 4'b0000);
      chk_cnt("both", 3, 6, 9, 12, 0);

      // Branch in the second stall cycle aborts the stall.
      do_reset("r1");
      @(negedge clk); hit2(); #1 chk_cyc("br0", 4'b1111, 1'b0);
      @(negedge clk); idle(1'b1); #1 chk_cyc("br1", 4'b0000, 1'b1);
      cycle_idle("br2", 4'b0000);
      cycle_idle("br3", 4'b0000);
      chk_cnt("br", 1, 1, 1, 1, 1);

      // Asynchronous reset in the second cycle of the LOAD_LAT=4 stall.
      do_reset("r2");
      @(negedge clk); hit2(); #1 chk_cyc("ar0", 4'b1111, 1'b0);
      cycle_idle("ar1", 4'b1110);
      #1 reset = 0; hit2();
      #1 chk_cyc("ar_low", 4'b0000, 1'b0);
      chk_cnt("ar_low", 0, 0, 0, 0, 0);
      @(negedge clk); reset = 1; idle(1'b0); #1 chk_cyc("ar_rel0", 4'b0000, 1'b0);
      cycle_idle("ar_rel1", 4'b0000);

      // Back-to-back dependent loads chain with no gap.
      @(negedge clk); hit2(); #1 chk_cyc("ch0", 4'b1111, 1'b0);
      cycle_idle("ch1", 4'b1110);
      @(negedge clk); hit2(); #1 chk_cyc("ch2", 4'b1111, 1'b0);
      cycle_idle("ch3", 4'b1010);
      cycle_idle("ch4", 4'b0000);
      chk_cnt("ch", 2, 4, 3, 4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
